exp_taylor_term_gen: RTL and testbench

- Sequential FP32 term generator that feeds the Taylor-series adder tree.
- Given x (IEEE-754 single), emits t0=1.0, t1=x, t2=x^2/2!, ..., t(n-1)=x^(n-1)/(n-1)! one term at a time on a valid/ready stream.
- Recurrence: t_k = (t_(k-1) * x) * R[k], where R[k] is a ROM constant equal to the FP32 value of 1/k.
- Replaces the hand-precomputed constant terms currently driven into the adder tree.

---
 rtl/exp_taylor_term_gen_if.sv | 27 ++
 rtl/exp_taylor_term_gen.sv | 167 ++++++++++++++++
 tb/tb_exp_taylor_term_gen.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_taylor_term_gen_if.sv
// Term stream interface for the Taylor-series term generator.
// The requester drives start/x/n_terms and term_ready; the generator drives
// the term stream and its status flags.
interface exp_taylor_term_gen_if #(
    parameter int N_W = 4
);
    logic           start;
    logic [31:0]    x;
    logic [N_W-1:0] n_terms;
    logic           busy;
    logic [31:0]    term_out;
    logic [N_W-1:0] term_idx;
    logic           term_last;
    logic           term_valid;
    logic           term_ready;
    logic           done;

    modport master (
        output start, x, n_terms, term_ready,
        input  busy, term_out, term_idx, term_last, term_valid, done
    );

    modport slave (
        input  start, x, n_terms, term_ready,
        output busy, term_out, term_idx, term_last, term_valid, done
    );
endinterface

// File: rtl/exp_taylor_term_gen.sv
// Sequential FP32 generator of the terms x^k/k! for k = 0..n-1.
// Each term is built from the previous one as (t * x) * (1/k), using one
// shared FP32 multiplier over two cycles, then held on the stream until taken.
module exp_taylor_term_gen #(
    parameter int MAX_TERMS = 12,
    parameter int N_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    exp_taylor_term_gen_if.slave  bus
);
    localparam logic [31:0]    FP_ONE   = 32'h3F80_0000;
    localparam logic [N_W-1:0] MAX_LAST = N_W'(MAX_TERMS - 1);

    typedef enum logic [1:0] {S_IDLE, S_OUT, S_MUL_X, S_MUL_R} state_e;

    state_e         state_q, state_d;
    logic [31:0]    acc_q, acc_d;
    logic [31:0]    x_q, x_d;
    logic [N_W-1:0] k_q, k_d;
    logic [N_W-1:0] last_q, last_d;
    logic           done_q, done_d;
    logic [31:0]    mul_b;
    logic [31:0]    mul_y;

    // FP32 reciprocals 1/k, round-to-nearest-even.
    function automatic logic [31:0] recip_rom(input logic [N_W-1:0] k);
        case (int'(k))
            1:       recip_rom = 32'h3F80_0000;
            2:       recip_rom = 32'h3F00_0000;
            3:       recip_rom = 32'h3EAA_AAAB;
            4:       recip_rom = 32'h3E80_0000;
            5:       recip_rom = 32'h3E4C_CCCD;
            6:       recip_rom = 32'h3E2A_AAAB;
            7:       recip_rom = 32'h3E12_4925;
            8:       recip_rom = 32'h3E00_0000;
            9:       recip_rom = 32'h3DE3_8E39;
            10:      recip_rom = 32'h3DCC_CCCD;
            11:      recip_rom = 32'h3DBA_2E8C;
            12:      recip_rom = 32'h3DAA_AAAB;
            13:      recip_rom = 32'h3D9D_89D9;
            14:      recip_rom = 32'h3D92_4925;
            15:      recip_rom = 32'h3D88_8889;
            default: recip_rom = FP_ONE;
        endcase
    endfunction

    // FP32 multiply, RNE, zero/subnormal inputs and underflow flush to signed
    // zero, overflow saturates to signed infinity. Inf/NaN inputs unsupported.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        logic [47:0] prod;
        logic        hi;
        logic [23:0] mant;
        logic        guard;
        logic        sticky;
        logic        rnd;
        logic [24:0] mant_r;
        logic [22:0] frac;
        logic [10:0] e_sum;
        logic [31:0] res;
        sign = a[31] ^ b[31];
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        hi   = prod[47];
        if (hi) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'b0, rnd};
        // A rounding carry-out leaves 1.000..0, renormalised by one more bit.
        frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        // Biased exponent plus the bias, kept unsigned: valid range is 128..381.
        e_sum  = {3'b0, a[30:23]} + {3'b0, b[30:23]} + {10'b0, hi} + {10'b0, mant_r[24]};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e_sum < 11'd128) begin
            res = {sign, 31'b0};
        end else if (e_sum > 11'd381) begin
            res = {sign, 8'hFF, 23'b0};
        end else begin
            res = {sign, 8'(e_sum - 11'd127), frac};
        end
        return res;
    endfunction

    assign mul_y = fmul(acc_q, mul_b);

    // Next-state, datapath update and multiplier operand select.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        x_d     = x_q;
        k_d     = k_q;
        last_d  = last_q;
        done_d  = 1'b0;
        mul_b   = (state_q == S_MUL_X) ? x_q : recip_rom(k_q);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d   = bus.x;
                    acc_d = FP_ONE;
                    k_d   = '0;
                    if (bus.n_terms == '0) begin
                        last_d = '0;
                    end else if (int'(bus.n_terms) > MAX_TERMS) begin
                        last_d = MAX_LAST;
                    end else begin
                        last_d = bus.n_terms - 1'b1;
                    end
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.term_ready) begin
                    if (k_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_MUL_X;
                    end
                end
            end
            S_MUL_X: begin
                acc_d   = mul_y;
                state_d = S_MUL_R;
            end
            S_MUL_R: begin
                acc_d   = mul_y;
                state_d = S_OUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            x_q     <= '0;
            k_q     <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            k_q     <= k_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.term_valid = (state_q == S_OUT);
    assign bus.term_last  = (state_q == S_OUT) && (k_q == last_q);
    assign bus.term_out   = acc_q;
    assign bus.term_idx   = k_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_exp_taylor_term_gen.sv
// Scoreboard bench for exp_taylor_term_gen: the driver pushes expected terms
// (hand constants or a real-arithmetic FP32 model) and a monitor pops and
// compares on every handshake, also checking hold-under-backpressure and done.
module tb_exp_taylor_term_gen;
    localparam int MAX_T = 12;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exp_taylor_term_gen_if #(.N_W(4)) bus ();

    exp_taylor_term_gen #(.MAX_TERMS(MAX_T), .N_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    bit   rand_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (real arithmetic) ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp_mag(input logic [31:0] b);
        if (b[30:23] == 8'd0) return 0.0;
        return (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
    endfunction

    // Round a positive magnitude to FP32 (RNE, flush-to-zero, saturate to inf).
    function automatic logic [31:0] to_fp(input logic s, input real mag);
        real    m = mag;
        int     e = 0;
        real    scaled, frac;
        int     ip;
        int     biased;
        if (mag == 0.0) return {s, 31'b0};
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        scaled = m * 8388608.0;
        ip     = $rtoi(scaled);
        frac   = scaled - real'(ip);
        if (frac > 0.5 || (frac == 0.5 && ip[0])) ip++;
        if (ip == 16777216) begin ip = 8388608; e++; end
        biased = e + 127;
        if (biased < 1)   return {s, 31'b0};
        if (biased > 254) return {s, 8'hFF, 23'b0};
        return {s, 8'(biased), ip[22:0]};
    endfunction

    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
        return to_fp(s, fp_mag(a) * fp_mag(b));
    endfunction

    function automatic int n_eff(input int n);
        if (n == 0) return 1;
        if (n > MAX_T) return MAX_T;
        return n;
    endfunction

    task automatic push_exp(input logic [31:0] d, input int idx, input int ne);
        exp_t e;
        e.data = d;
        e.idx  = 4'(idx);
        e.last = (idx == ne - 1);
        sb.push_back(e);
    endtask

    // Terms x^k/k! via the recurrence t_k = (t_(k-1)*x) * fp32(1/k).
    task automatic push_model(input logic [31:0] xv, input int n);
        int          ne = n_eff(n);
        logic [31:0] t  = 32'h3F80_0000;
        for (int k = 0; k < ne; k++) begin
            if (k > 0) t = fmul_ref(fmul_ref(t, xv), to_fp(1'b0, 1.0 / real'(k)));
            push_exp(t, k, ne);
        end
    endtask

    task automatic push_list(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                             input logic [31:0] v3, input logic [31:0] v4, input int ne);
        logic [31:0] v[5];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3; v[4] = v4;
        for (int k = 0; k < ne; k++) push_exp(v[k], k, ne);
    endtask

    function automatic logic [31:0] rand_x(input int emin, input int emax);
        logic       s = 1'($urandom_range(0, 1));
        logic [7:0] e = 8'($urandom_range(emin, emax));
        logic [22:0] m = 23'($urandom);
        return {s, e, m};
    endfunction

    // ---------------- ready driver ----------------
    initial begin
        bus.term_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.term_ready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          prev_stall = 1'b0;
        bit          prev_last_hs = 1'b0;
        logic [31:0] p_data = '0;
        logic [3:0]  p_idx = '0;
        logic        p_last = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall   = 1'b0;
                prev_last_hs = 1'b0;
                continue;
            end
            if (bus.start && !bus.busy) start_cyc = cyc;
            if (prev_stall) begin
                check("hold_valid", 32'(bus.term_valid), 32'd1);
                check("hold_data", bus.term_out, p_data);
                check("hold_idx", 32'(bus.term_idx), 32'(p_idx));
                check("hold_last", 32'(bus.term_last), 32'(p_last));
            end
            if (prev_last_hs || bus.done) begin
                check("done_pulse", 32'(bus.done), 32'(prev_last_hs));
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end
            if (bus.term_valid && bus.term_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_term: got idx %0d data %h expected no term", bus.term_idx, bus.term_out);
                end else begin
                    e = sb.pop_front();
                    check("term_data", bus.term_out, e.data);
                    check("term_idx", 32'(bus.term_idx), 32'(e.idx));
                    check("term_last", 32'(bus.term_last), 32'(e.last));
                    check("busy_with_valid", 32'(bus.busy), 32'd1);
                end
                if (bus.term_idx == 4'd0) first_cyc = cyc;
                if (bus.term_last) last_cyc = cyc;
            end
            prev_stall   = bus.term_valid && !bus.term_ready;
            prev_last_hs = bus.term_valid && bus.term_ready && bus.term_last;
            p_data = bus.term_out;
            p_idx  = bus.term_idx;
            p_last = bus.term_last;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] xv, input int n, input bit pulse_mid);
        int t = 0;
        while (bus.busy && t < 1000) begin @(posedge clk); #1; t++; end
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.x       = xv;
        bus.n_terms = 4'(n);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.x       = $urandom;
        bus.n_terms = 4'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        t = 0;
        while (!bus.done && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
            if (pulse_mid && t == 6 && bus.busy) begin
                bus.start = 1'b1;
                bus.x     = $urandom;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (t >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_timeout: got no done expected done within 3000 cycles");
            sb.delete();
        end else begin
            check("all_terms_drained", 32'(sb.size()), 32'd0);
            if (!rand_mode) begin
                check("first_latency", 32'(first_cyc - start_cyc), 32'd1);
                check("last_latency", 32'(last_cyc - start_cyc), 32'(3 * n_eff(n) - 2));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] xv;
        int          n;
        int          t;
        bus.start   = 1'b0;
        bus.x       = '0;
        bus.n_terms = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.term_valid), 32'd0);
        check("rst_last", 32'(bus.term_last), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_term_out", bus.term_out, 32'd0);
        check("rst_term_idx", 32'(bus.term_idx), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors.
        push_list(32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3E2AAAAB, 32'h0, 4);
        issue(32'h3F800000, 4, 1'b0);
        push_list(32'h3F800000, 32'h40000000, 32'h40000000, 32'h3FAAAAAB, 32'h3F2AAAAB, 5);
        issue(32'h40000000, 5, 1'b0);
        push_model(32'h3FD9999A, 6);
        issue(32'h3FD9999A, 6, 1'b0);

        // Boundaries.
        push_list(32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h0, 1);
        issue(32'h40400000, 0, 1'b0);
        xv = rand_x(118, 132);
        push_model(xv, 15);
        issue(xv, 15, 1'b0);
        push_list(32'h3F800000, 32'hBF800000, 32'h3F000000, 32'hBE2AAAAB, 32'h0, 4);
        issue(32'hBF800000, 4, 1'b0);
        push_list(32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h0, 5);
        issue(32'h00000000, 5, 1'b0);

        // Random arguments and lengths, then tiny arguments that underflow.
        for (int r = 0; r < 8; r++) begin
            xv = rand_x(112, 138);
            n  = $urandom_range(0, 15);
            push_model(xv, n);
            issue(xv, n, 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            xv = rand_x(30, 70);
            push_model(xv, 6);
            issue(xv, 6, 1'b0);
        end

        // Backpressure with a start pulse while busy.
        rand_mode = 1'b1;
        for (int r = 0; r < 5; r++) begin
            xv = rand_x(115, 135);
            n  = $urandom_range(6, 12);
            push_model(xv, n);
            issue(xv, n, 1'b1);
        end
        rand_mode = 1'b0;
        repeat (2) @(posedge clk);

        // Reset while the multiplier is building term 3.
        push_model(32'h3FC00000, 5);
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.x       = 32'h3FC00000;
        bus.n_terms = 4'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t = 0;
        while (!(bus.term_valid && bus.term_idx == 4'd2) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reach_idx2", 32'(bus.term_idx), 32'd2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(bus.term_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_term_idx", 32'(bus.term_idx), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        xv = rand_x(120, 130);
        push_model(xv, 3);
        issue(xv, 3, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
